// File: rtl/divider_seq_pkg.sv
// Shared types for the divider profile sequencer: controller states, the
// profile-table record and the segment-index width helper.
package divider_seq_pkg;

    localparam int SEQ_DIV_W = 32;
    localparam int SEQ_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [SEQ_DIV_W-1:0] div;
        logic [SEQ_CNT_W-1:0] cnt;
    } seg_rec_t;

    function automatic int seg_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/divider_profile_sequencer_rate_tick_counter.sv
// Period counter: counts 0..div and flags the period end; wraps to 0 on its own,
// so back-to-back periods are gapless.
module rate_tick_counter #(
    parameter int DIV_W = 32
) (
    input  logic             i_CLK,
    input  logic             i_RESET,
    input  logic             en,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             period_end
);

    logic [DIV_W-1:0] count;

    // Equality compare keeps an all-ones divide value overflow-free.
    assign period_end = en && (count == div);

    always_ff @(posedge i_CLK) begin
        if (i_RESET || clear) begin
            count <= '0;
        end else if (en) begin
            count <= period_end ? '0 : count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/divider_profile_sequencer.sv
// Steps a tick divider through a programmable table of {divide, tick count}
// segments, producing a single-cycle rate tick with gapless segment changes.
module divider_profile_sequencer
    import divider_seq_pkg::*;
#(
    parameter int NUM_SEG = 8,
    parameter int DIV_W   = SEQ_DIV_W,
    parameter int CNT_W   = SEQ_CNT_W,
    parameter int SEG_W   = seg_width(NUM_SEG)
) (
    input  logic             i_CLK,
    input  logic             i_RESET,
    input  logic             i_CFG_WE,
    input  logic [SEG_W-1:0] i_CFG_ADDR,
    input  logic [DIV_W-1:0] i_CFG_DIV,
    input  logic [CNT_W-1:0] i_CFG_CNT,
    input  logic [SEG_W-1:0] i_LAST_SEG,
    input  logic             i_LOOP,
    input  logic             i_START,
    input  logic             i_STOP,
    output logic             o_TICK,
    output logic             o_BUSY,
    output logic             o_DONE,
    output logic [SEG_W-1:0] o_SEG,
    output logic [DIV_W-1:0] o_DIV_VALUE,
    output logic             o_CFG_ERR
);

    seq_state_t state, state_nxt;
    seg_rec_t   tbl [NUM_SEG];

    logic [SEG_W-1:0] seg;
    logic [SEG_W-1:0] last_q;
    logic [SEG_W-1:0] last_clamped;
    logic             loop_q;
    logic [CNT_W-1:0] seg_ticks;
    logic [CNT_W-1:0] cur_cnt;
    logic [CNT_W-1:0] cnt_m1;
    logic [DIV_W-1:0] div_value;
    logic             tick_q;
    logic             cfg_err_q;
    logic             run;
    logic             start_go;
    logic             period_end;
    logic             at_last_tick;
    logic             addr_ok;

    assign run      = (state == RUN);
    assign start_go = !run && i_START && !i_STOP;
    assign addr_ok  = ({1'b0, i_CFG_ADDR} < (SEG_W + 1)'(NUM_SEG));

    assign last_clamped = ({1'b0, i_LAST_SEG} > (SEG_W + 1)'(NUM_SEG - 1))
                        ? SEG_W'(NUM_SEG - 1) : i_LAST_SEG;

    // A programmed count of 0 behaves as a one-tick segment.
    assign cur_cnt      = CNT_W'(tbl[seg].cnt);
    assign cnt_m1       = (cur_cnt == '0) ? '0 : cur_cnt - CNT_W'(1);
    assign at_last_tick = (seg_ticks == cnt_m1);

    rate_tick_counter #(
        .DIV_W (DIV_W)
    ) u_rate_tick_counter (
        .i_CLK      (i_CLK),
        .i_RESET    (i_RESET),
        .en         (run),
        .clear      (!run || i_STOP),
        .div        (div_value),
        .period_end (period_end)
    );

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (i_START && !i_STOP) state_nxt = RUN;
            end
            RUN: begin
                if (i_STOP) begin
                    state_nxt = IDLE;
                end else if (period_end && at_last_tick && (seg == last_q) && !loop_q) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            for (int i = 0; i < NUM_SEG; i++) tbl[i] <= '0;
            seg       <= '0;
            last_q    <= '0;
            loop_q    <= 1'b0;
            seg_ticks <= '0;
            div_value <= '0;
            tick_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            tick_q    <= run && period_end && !i_STOP;
            cfg_err_q <= run && i_CFG_WE;

            if (start_go) begin
                seg       <= '0;
                seg_ticks <= '0;
                div_value <= DIV_W'(tbl[0].div);
                last_q    <= last_clamped;
                loop_q    <= i_LOOP;
            end else if (run && i_STOP) begin
                seg_ticks <= '0;
            end else if (run && period_end) begin
                if (!at_last_tick) begin
                    seg_ticks <= seg_ticks + CNT_W'(1);
                end else if (seg != last_q) begin
                    seg       <= seg + SEG_W'(1);
                    seg_ticks <= '0;
                    div_value <= DIV_W'(tbl[seg + SEG_W'(1)].div);
                end else if (loop_q) begin
                    seg       <= '0;
                    seg_ticks <= '0;
                    div_value <= DIV_W'(tbl[0].div);
                end
            end

            // Table is frozen while a profile runs; start reads the old entry.
            if (i_CFG_WE && !run && addr_ok) begin
                tbl[i_CFG_ADDR] <= '{div: SEQ_DIV_W'(i_CFG_DIV), cnt: SEQ_CNT_W'(i_CFG_CNT)};
            end
        end
    end

    assign o_TICK      = tick_q;
    assign o_BUSY      = run;
    assign o_DONE      = (state == DONE);
    assign o_SEG       = seg;
    assign o_DIV_VALUE = div_value;
    assign o_CFG_ERR   = cfg_err_q;

endmodule

// File: tb/tb_divider_profile_sequencer.sv
// Bench for divider_profile_sequencer: directed profile scenarios with literal
// tick times plus randomized traffic against a cycle-level behavioural model.
module tb_divider_profile_sequencer;

    localparam int NUM_SEG = 8;
    localparam int DIV_W   = 32;
    localparam int CNT_W   = 16;
    localparam int SEG_W   = 3;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DONE  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [SEG_W-1:0] cfg_addr;
    logic [DIV_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_cnt;
    logic [SEG_W-1:0] last_seg;
    logic             loop_en;
    logic             start;
    logic             stop;
    logic             tick;
    logic             busy;
    logic             done;
    logic [SEG_W-1:0] seg;
    logic [DIV_W-1:0] div_value;
    logic             cfg_err;

    always #5 clk = ~clk;

    divider_profile_sequencer #(
        .NUM_SEG (NUM_SEG),
        .DIV_W   (DIV_W),
        .CNT_W   (CNT_W),
        .SEG_W   (SEG_W)
    ) dut (
        .i_CLK       (clk),
        .i_RESET     (rst),
        .i_CFG_WE    (cfg_we),
        .i_CFG_ADDR  (cfg_addr),
        .i_CFG_DIV   (cfg_div),
        .i_CFG_CNT   (cfg_cnt),
        .i_LAST_SEG  (last_seg),
        .i_LOOP      (loop_en),
        .i_START     (start),
        .i_STOP      (stop),
        .o_TICK      (tick),
        .o_BUSY      (busy),
        .o_DONE      (done),
        .o_SEG       (seg),
        .o_DIV_VALUE (div_value),
        .o_CFG_ERR   (cfg_err)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    t0 = 0;
    bit    rec_on = 1'b0;
    string tick_log = "";

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic chk_str(input string name, input string got, input string exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got ticks [%s] expected [%s]", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks cycles left until the current period ends and ticks done in the segment.
    int          m_mode;
    logic [31:0] m_tdiv [NUM_SEG];
    int          m_tcnt [NUM_SEG];
    logic [31:0] m_left;
    logic [31:0] m_div;
    int          m_ticks;
    int          m_seg;
    int          m_last;
    bit          m_loop;
    bit          m_tick;
    bit          m_err;
    bit          m_started = 1'b0;

    task automatic m_load(input int s);
        m_seg   = s;
        m_div   = m_tdiv[s];
        m_left  = m_tdiv[s];
        m_ticks = 0;
    endtask

    always @(posedge clk) begin
        m_started = 1'b1;
        if (rst) begin
            m_mode = M_IDLE;
            for (int i = 0; i < NUM_SEG; i++) begin
                m_tdiv[i] = 0;
                m_tcnt[i] = 0;
            end
            m_left = 0; m_div = 0; m_ticks = 0; m_seg = 0; m_last = 0;
            m_loop = 0; m_tick = 0; m_err = 0;
        end else begin
            m_tick = 0;
            m_err  = 0;
            if (m_mode == M_RUN) begin
                if (cfg_we) m_err = 1;
                if (stop) begin
                    m_mode = M_IDLE;
                end else if (m_left == 0) begin
                    m_tick = 1;
                    m_ticks++;
                    if (m_ticks >= ((m_tcnt[m_seg] == 0) ? 1 : m_tcnt[m_seg])) begin
                        if (m_seg != m_last) m_load(m_seg + 1);
                        else if (m_loop)     m_load(0);
                        else                 m_mode = M_DONE;
                    end else begin
                        m_left = m_div;
                    end
                end else begin
                    m_left = m_left - 1;
                end
            end else begin
                if (start && !stop) begin
                    m_mode = M_RUN;
                    m_last = (int'(last_seg) > NUM_SEG - 1) ? NUM_SEG - 1 : int'(last_seg);
                    m_loop = loop_en;
                    m_load(0);
                end
                if (cfg_we) begin
                    m_tdiv[cfg_addr] = cfg_div;
                    m_tcnt[cfg_addr] = int'(cfg_cnt);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("tick",    64'(tick),      64'(m_tick));
            chk("busy",    64'(busy),      64'(m_mode == M_RUN));
            chk("done",    64'(done),      64'(m_mode == M_DONE));
            chk("seg",     64'(seg),       64'(m_seg));
            chk("div",     64'(div_value), 64'(m_div));
            chk("cfg_err", 64'(cfg_err),   64'(m_err));
        end
        if (rec_on && tick) tick_log = $sformatf("%s%0d,", tick_log, cyc - t0);
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int rel);
        while (cyc - t0 < rel) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    task automatic write_seg(input int a, input logic [DIV_W-1:0] d, input logic [CNT_W-1:0] c);
        cfg_we   = 1'b1;
        cfg_addr = SEG_W'(a);
        cfg_div  = d;
        cfg_cnt  = c;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic start_run(input int last, input bit lp);
        last_seg = SEG_W'(last);
        loop_en  = lp;
        start    = 1'b1;
        t0       = cyc;
        tick_log = "";
        rec_on   = 1'b1;
        wait_cyc(1);
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_div = 0; cfg_cnt = 0;
        last_seg = 0; loop_en = 0; start = 0; stop = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 0);
        chk("reset_div",  64'(div_value), 0);

        // Two-segment profile, no loop
        write_seg(0, 3, 2);
        write_seg(1, 1, 3);
        start_run(1, 0);
        wait_cyc(8);  chk("s1_seg_at8", 64'(seg), 0);
        wait_cyc(9);  chk("s1_seg_at9", 64'(seg), 1);
        chk("s1_div_at9", 64'(div_value), 1);
        wait_cyc(15); chk("s1_done_at15", 64'(done), 1);
        chk("s1_busy_at15", 64'(busy), 0);
        chk("s1_tick_at15", 64'(tick), 1);
        wait_cyc(18); chk_str("s1_ticks", tick_log, "5,9,11,13,15,");

        // Same table, looping
        start_run(1, 1);
        wait_cyc(15); chk("s2_seg_at15", 64'(seg), 0);
        chk("s2_busy_at15", 64'(busy), 1);
        wait_cyc(26); chk_str("s2_ticks", tick_log, "5,9,11,13,15,19,23,25,");
        chk("s2_not_done", 64'(done), 0);
        stop = 1'b1;
        wait_cyc(27); stop = 1'b0;
        chk("s2_stopped", 64'(busy), 0);

        // Abort on a period end, then restart
        start_run(1, 0);
        wait_cyc(8);  stop = 1'b1;
        wait_cyc(9);  stop = 1'b0;
        chk("s3_busy_at9", 64'(busy), 0);
        chk("s3_tick_at9", 64'(tick), 0);
        wait_cyc(12); start = 1'b1;
        wait_cyc(13); start = 1'b0;
        wait_cyc(18); chk_str("s3_ticks", tick_log, "5,17,");
        stop = 1'b1;
        wait_cyc(19); stop = 1'b0;

        // Table write while running is rejected
        start_run(1, 0);
        wait_cyc(3);  cfg_we = 1'b1; cfg_addr = 0; cfg_div = 7; cfg_cnt = 2;
        wait_cyc(4);  cfg_we = 1'b0;
        chk("s4_cfg_err", 64'(cfg_err), 1);
        chk("s4_div", 64'(div_value), 3);
        wait_cyc(16);
        start_run(1, 0);
        wait_cyc(16); chk_str("s4_ticks_after", tick_log, "5,9,11,13,15,");

        // Reset mid-run, then a run on the cleared table
        start_run(1, 0);
        wait_cyc(6);  rst = 1'b1;
        wait_cyc(7);  rst = 1'b0;
        chk("s5_busy", 64'(busy), 0);
        chk("s5_seg",  64'(seg), 0);
        chk("s5_div",  64'(div_value), 0);
        chk("s5_done", 64'(done), 0);
        start_run(0, 0);
        wait_cyc(2);  chk("s5_tick_at2", 64'(tick), 1);
        chk("s5_done_at2", 64'(done), 1);
        wait_cyc(3);  chk_str("s5_ticks", tick_log, "2,");

        // Single segment, DIV=0 CNT=4; then START+STOP together in DONE
        write_seg(0, 0, 4);
        start_run(0, 0);
        wait_cyc(5);  chk("s6_done_at5", 64'(done), 1);
        wait_cyc(6);  chk_str("s6_ticks", tick_log, "2,3,4,5,");
        start = 1'b1; stop = 1'b1;
        wait_cyc(7);  start = 1'b0; stop = 1'b0;
        chk("s6_start_stop", 64'(busy), 0);
        rec_on = 1'b0;

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 399) == 0);
            cfg_we   = ($urandom_range(0, 4) == 0);
            cfg_addr = SEG_W'($urandom_range(0, NUM_SEG - 1));
            cfg_div  = ($urandom_range(0, 15) == 0) ? '1 : DIV_W'($urandom_range(0, 4));
            cfg_cnt  = CNT_W'($urandom_range(0, 3));
            last_seg = SEG_W'($urandom_range(0, 3));
            loop_en  = $urandom_range(0, 1);
            start    = ($urandom_range(0, 5) == 0);
            stop     = ($urandom_range(0, 39) == 0);
        end
        @(negedge clk);
        rst = 0; cfg_we = 0; start = 0; stop = 0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
